// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES tables, FSM state type and GF(2^8) helpers
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// rtl/aes_inv_round_comb.sv - one combinational AES inverse round with mix-columns bypass
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  input  logic         bypass,
  output logic [127:0] data_out
);

  logic [7:0] ark_b [16];
  logic [7:0] mix_b [16];

  // Byte i sits at bits 127-8i; byte index = row + 4*col.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = r + 4 * c;
      localparam int SRC = r + 4 * ((c + 4 - r) % 4);
      assign ark_b[DST] = INV_SBOX[data_in[127-8*SRC -: 8]] ^ round_key[127-8*DST -: 8];
    end
    assign mix_b[4*c+0] = gmul(ark_b[4*c+0], 8'h0e) ^ gmul(ark_b[4*c+1], 8'h0b) ^
                          gmul(ark_b[4*c+2], 8'h0d) ^ gmul(ark_b[4*c+3], 8'h09);
    assign mix_b[4*c+1] = gmul(ark_b[4*c+0], 8'h09) ^ gmul(ark_b[4*c+1], 8'h0e) ^
                          gmul(ark_b[4*c+2], 8'h0b) ^ gmul(ark_b[4*c+3], 8'h0d);
    assign mix_b[4*c+2] = gmul(ark_b[4*c+0], 8'h0d) ^ gmul(ark_b[4*c+1], 8'h09) ^
                          gmul(ark_b[4*c+2], 8'h0e) ^ gmul(ark_b[4*c+3], 8'h0b);
    assign mix_b[4*c+3] = gmul(ark_b[4*c+0], 8'h0b) ^ gmul(ark_b[4*c+1], 8'h0d) ^
                          gmul(ark_b[4*c+2], 8'h09) ^ gmul(ark_b[4*c+3], 8'h0e);
  end

  // Repack bytes, skipping InvMixColumns for the last round.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < 16; i++) begin
      data_out[127-8*i -: 8] = bypass ? ark_b[i] : mix_b[i];
    end
  end

endmodule

// File: rtl/aes_inv_round_engine.sv
// rtl/aes_inv_round_engine.sv - iterative AES-128 decryptor with on-the-fly inverse key schedule
module aes_inv_round_engine
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic [127:0] key_out
);

  fsm_t         fsm;
  fsm_t         fsm_next;
  logic [3:0]   cnt;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic [127:0] pt_q;
  logic [127:0] key_out_q;
  logic [127:0] rk_prev;
  logic [127:0] round_out;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [3:0]   rcon_idx;

  // key_q holds round key cnt+1; derive round key cnt from it.
  always_comb begin
    {w0, w1, w2, w3} = key_q;
    n3       = w3 ^ w2;
    n2       = w2 ^ w1;
    n1       = w1 ^ w0;
    rot      = {n3[23:0], n3[31:24]};
    sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    rcon_idx = cnt + 4'd1;
    n0       = w0 ^ sub ^ {RCON[rcon_idx], 24'h000000};
    rk_prev  = {n0, n1, n2, n3};
  end

  aes_inv_round_comb u_round (
    .data_in   (st_q),
    .round_key (rk_prev),
    .bypass    (fsm == FINAL),
    .data_out  (round_out)
  );

  // State register for the control FSM.
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    fsm_next  = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = ROUND;
      end
      ROUND: begin
        if (cnt == 4'd1) fsm_next = FINAL;
      end
      FINAL: begin
        fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Datapath: load on accept, one round per cycle, capture result in FINAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      st_q      <= '0;
      key_q     <= '0;
      pt_q      <= '0;
      key_out_q <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st_q  <= state ^ key;
            key_q <= key;
            cnt   <= 4'd9;
          end
        end
        ROUND: begin
          st_q  <= round_out;
          key_q <= rk_prev;
          cnt   <= cnt - 4'd1;
        end
        FINAL: begin
          pt_q      <= round_out;
          key_out_q <= rk_prev;
        end
        default: ;
      endcase
    end
  end

  assign pt      = pt_q;
  assign key_out = key_out_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// tb/tb_aes_inv_round_engine.sv - scoreboard bench for aes_inv_round_engine
module tb_aes_inv_round_engine;

  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_i;
  logic [127:0] key_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic [127:0] key_out;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_accept = 0;
  int   first_accept = 0;
  logic prev_ov = 1'b0;

  aes_inv_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state     (state_i),
    .key       (key_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        chk("pt", pt, e.pt);
        chk("key_out", key_out, e.key);
        chk("latency", 128'(cyc), 128'(e.cyc + 10));
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [127:0] s, input logic [127:0] k,
                      input logic [127:0] p, input logic [127:0] kk);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 128'(in_ready), 128'd1);
      return;
    end
    state_i  = s;
    key_i    = k;
    in_valid = 1'b1;
    sb.push_back('{p, kk, cyc + 1});
    last_accept = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    state_i  = {4{$urandom}};
    key_i    = {4{$urandom}};
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_i   = '0;
    key_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_pt", pt, 128'd0);
    chk("rst_key_out", key_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vector 1.
    send(V1_CT, V1_K10, V1_PT, V1_K0);
    drain();

    // Vector 2 with back-pressure and ignored in_valid while done.
    out_ready = 1'b0;
    send(V2_CT, V2_K10, V2_PT, V2_K0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach", 128'(out_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_pt", pt, V2_PT);
      chk("hold_key", key_out, V2_K0);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      chk("hold_out_valid", 128'(out_valid), 128'd1);
      in_valid = 1'b1;
      state_i  = {4{$urandom}};
      key_i    = {4{$urandom}};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", 128'(out_valid), 128'd0);
    chk("rel_in_ready", 128'(in_ready), 128'd1);
    chk("rel_pt", pt, V2_PT);
    chk("rel_key", key_out, V2_K0);

    // Reset during round 5 aborts the block.
    send(V1_CT, V1_K10, V1_PT, V1_K0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_pt", pt, 128'd0);
    chk("abort_key", key_out, 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    send(V1_CT, V1_K10, V1_PT, V1_K0);
    drain();

    // Back-to-back blocks with out_ready held high.
    send(V1_CT, V1_K10, V1_PT, V1_K0);
    first_accept = last_accept;
    send(V2_CT, V2_K10, V2_PT, V2_K0);
    chk("b2b_gap", 128'(last_accept - first_accept), 128'd12);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
